// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory request/acknowledge bus between the fetch
//               unit (master) and the instruction memory (slave).
//               ImemReq   : request, fetcher -> memory
//               ImemAddr  : word-aligned fetch address, fetcher -> memory
//               ImemAck   : transfer completes when ImemReq & ImemAck
//               ImemRdata : instruction word, valid in the ack cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemRdata
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemRdata
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with a 2-entry {instr, pc} FIFO.
//               Keeps a fetch PC, requests instruction words while the FIFO
//               has room, and presents the head entry to decode. A redirect
//               (PCSrc) flushes the FIFO, drops any transfer completing in
//               the same cycle and retargets the fetch PC.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous, active-low reset
//               PCSrc      - redirect request
//               Result     - redirect target (low two bits ignored)
//               IStall     - downstream not ready, hold head instruction
//               imem       - instruction-memory bus (master modport)
//               Instr      - head instruction, MOV r0,r0 bubble when empty
//               InstrValid - Instr holds a real fetched instruction
//               PCPlus8    - head PC + 8 (fetch PC + 8 when empty)
//               FetchCount - pushed-instruction count (FETCH_PERFCNT_EN only)
//               FlushCount - flush-event count (FETCH_PERFCNT_EN only)
// Config      : define FETCH_PERFCNT_EN to add the saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        PCSrc,
  input  wire logic [31:0] Result,
  input  wire logic        IStall,
  fetch_unit_if.master     imem,
  output logic      [31:0] Instr,
  output logic             InstrValid,
  output logic      [31:0] PCPlus8
`ifdef FETCH_PERFCNT_EN
  ,
  output logic      [31:0] FetchCount,
  output logic      [15:0] FlushCount
`endif
);

  localparam logic [31:0] c_NOP = 32'hE1A0_0000;

  // Registered state
  logic [31:0] r_fetch_pc;
  logic [31:0] r_instr_q [0:1];
  logic [31:0] r_pc_q    [0:1];
  logic        r_head;
  logic [1:0]  r_count;
  // Cleared by reset and set on the first clock edge afterwards, so the
  // request stays low throughout reset even though the FIFO is empty.
  logic        r_run;

  // Combinational control
  logic        w_xfer;
  logic        w_push;
  logic        w_pop;
  logic        w_tail;
  logic [31:0] w_target;

  assign imem.ImemReq  = r_run & (r_count != 2'd2);
  assign imem.ImemAddr = r_fetch_pc;

  assign w_xfer   = imem.ImemReq & imem.ImemAck;
  assign w_push   = w_xfer & ~PCSrc;
  assign w_pop    = (r_count != 2'd0) & ~IStall & ~PCSrc;
  // A push only happens with count < 2, so the tail slot is head + count[0].
  assign w_tail   = r_head ^ r_count[0];
  assign w_target = Result & 32'hFFFF_FFFC;

  assign InstrValid = (r_count != 2'd0);

  always_comb begin
    Instr   = c_NOP;
    PCPlus8 = r_fetch_pc + 32'd8;
    if (r_count != 2'd0) begin
      Instr   = r_instr_q[r_head];
      PCPlus8 = r_pc_q[r_head] + 32'd8;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc   <= RESET_PC;
      r_head       <= 1'b0;
      r_count      <= 2'd0;
      r_run        <= 1'b0;
      r_instr_q[0] <= c_NOP;
      r_instr_q[1] <= c_NOP;
      r_pc_q[0]    <= 32'd0;
      r_pc_q[1]    <= 32'd0;
    end else begin
      r_run <= 1'b1;
      if (PCSrc) begin
        // Redirect wins over everything: flush and retarget.
        r_count    <= 2'd0;
        r_head     <= 1'b0;
        r_fetch_pc <= w_target;
      end else begin
        if (w_push) begin
          r_instr_q[w_tail] <= imem.ImemRdata;
          r_pc_q[w_tail]    <= r_fetch_pc;
          r_fetch_pc        <= r_fetch_pc + 32'd4;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef FETCH_PERFCNT_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_flush_evt;

  // A flush event is a redirect that throws away queued or arriving work.
  assign w_flush_evt = PCSrc & ((r_count != 2'd0) | w_xfer);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= 32'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_push && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_flush_evt && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign FetchCount = r_fetch_cnt;
  assign FlushCount = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. The memory model
//               returns the bitwise inverse of the address as the instruction
//               word, so every expected Instr value is ~pc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        PCSrc;
  logic [31:0] Result;
  logic        IStall;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PCPlus8;
`ifdef FETCH_PERFCNT_EN
  logic [31:0] FetchCount;
  logic [15:0] FlushCount;
`endif

  int n_checks;
  int n_errors;

  fetch_unit_if bus ();

  assign bus.ImemRdata = ~bus.ImemAddr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc      (PCSrc),
    .Result     (Result),
    .IStall     (IStall),
    .imem       (bus),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PCPlus8    (PCPlus8)
`ifdef FETCH_PERFCNT_EN
    ,
    .FetchCount (FetchCount),
    .FlushCount (FlushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'd0, InstrValid}, 32'd1);
    chk({tag, ".instr"}, Instr, ~pc);
    chk({tag, ".pc8"}, PCPlus8, pc + 32'd8);
    chk({tag, ".addr"}, bus.ImemAddr, addr);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    PCSrc = 1'b0;
    Result = 32'd0;
    IStall = 1'b0;
    bus.ImemAck = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", {31'd0, bus.ImemReq}, 32'd0);
    chk("rst.valid", {31'd0, InstrValid}, 32'd0);
    chk("rst.instr", Instr, 32'hE1A0_0000);
    chk("rst.pc8", PCPlus8, 32'd8);
    chk("rst.addr", bus.ImemAddr, 32'd0);

    // Release between edges; first request after the next edge
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("start.req", {31'd0, bus.ImemReq}, 32'd1);
    chk("start.addr", bus.ImemAddr, 32'd0);
    chk("start.valid", {31'd0, InstrValid}, 32'd0);

    // Streaming: one instruction per cycle, head PC trails fetch PC by 4
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_head("stream", 32'(4 * (i - 1)), 32'(4 * i));
    end

    // Stall with FIFO filling: head pc 12 held, fetch stops at 20
    IStall = 1'b1;
    repeat (5) step();
    chk_head("stall", 32'd12, 32'd20);
    chk("stall.req", {31'd0, bus.ImemReq}, 32'd0);
    IStall = 1'b0;
    step();
    chk_head("resume0", 32'd16, 32'd20);
    chk("resume0.req", {31'd0, bus.ImemReq}, 32'd1);
    step();
    chk_head("resume1", 32'd20, 32'd24);

    // Redirect with a completing transfer: word dropped, aligned target
    PCSrc = 1'b1;
    Result = 32'h0000_0103;
    step();
    PCSrc = 1'b0;
    chk("redir.valid", {31'd0, InstrValid}, 32'd0);
    chk("redir.instr", Instr, 32'hE1A0_0000);
    chk("redir.addr", bus.ImemAddr, 32'h0000_0100);
    chk("redir.pc8", PCPlus8, 32'h0000_0108);
    step();
    chk_head("redir.first", 32'h100, 32'h104);

    // Back-to-back redirects, then a stalled memory
    PCSrc = 1'b1;
    Result = 32'h0000_0200;
    step();
    chk("b2b.addr0", bus.ImemAddr, 32'h200);
    chk("b2b.valid0", {31'd0, InstrValid}, 32'd0);
    Result = 32'h0000_0300;
    step();
    chk("b2b.addr1", bus.ImemAddr, 32'h300);
    chk("b2b.valid1", {31'd0, InstrValid}, 32'd0);
    PCSrc = 1'b0;
    bus.ImemAck = 1'b0;
    step();
    chk("noack.valid", {31'd0, InstrValid}, 32'd0);
    chk("noack.addr", bus.ImemAddr, 32'h300);
    chk("noack.req", {31'd0, bus.ImemReq}, 32'd1);
    bus.ImemAck = 1'b1;
    step();
    chk_head("b2b.first", 32'h300, 32'h304);

    // Address wrap
    PCSrc = 1'b1;
    Result = 32'hFFFF_FFFC;
    step();
    PCSrc = 1'b0;
    chk("wrap.addr0", bus.ImemAddr, 32'hFFFF_FFFC);
    step();
    chk("wrap.instr", Instr, 32'h0000_0003);
    chk("wrap.pc8", PCPlus8, 32'h0000_0004);
    chk("wrap.addr1", bus.ImemAddr, 32'h0000_0000);

    // Pending request then asynchronous reset mid-cycle
    PCSrc = 1'b1;
    Result = 32'h0000_0400;
    step();
    PCSrc = 1'b0;
    bus.ImemAck = 1'b0;
    repeat (3) step();
    chk("hang.addr", bus.ImemAddr, 32'h400);
    #3;
    reset = 1'b0;
    #1;
    chk("areset.req", {31'd0, bus.ImemReq}, 32'd0);
    chk("areset.addr", bus.ImemAddr, 32'd0);
    chk("areset.valid", {31'd0, InstrValid}, 32'd0);
    chk("areset.pc8", PCPlus8, 32'd8);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rerun.req", {31'd0, bus.ImemReq}, 32'd1);
    chk("rerun.addr", bus.ImemAddr, 32'd0);

    // 10 fetches and 2 flushing redirects
    bus.ImemAck = 1'b1;
    repeat (9) step();
    chk_head("perf.nine", 32'd32, 32'd36);
    bus.ImemAck = 1'b0;
    PCSrc = 1'b1;
    Result = 32'h0000_0800;
    step();
    PCSrc = 1'b0;
    bus.ImemAck = 1'b1;
    step();
    chk_head("perf.ten", 32'h800, 32'h804);
    bus.ImemAck = 1'b0;
    PCSrc = 1'b1;
    Result = 32'h0000_0900;
    step();
    PCSrc = 1'b0;
    chk("perf.addr", bus.ImemAddr, 32'h900);
`ifdef FETCH_PERFCNT_EN
    chk("perf.fetch", FetchCount, 32'd10);
    chk("perf.flush", {16'd0, FlushCount}, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
